inst_fetch_ctrl: RTL

- Sequences the instruction memory controller: owns the PC, drives its chip-enable and word address, and captures the combinational instruction return into a 2-entry fetch buffer.
- Presents instructions to the decode stage over a valid/ready handshake.
- Handles stall, branch redirect with flush, misaligned targets and end-of-ROM.
- Sits between the pipeline control/branch logic and the instruction memory controller.

---
 rtl/inst_fetch_ctrl_if.sv | 24 ++
 rtl/inst_fetch_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus: instruction memory request/return plus decode valid/ready handshake.
// Latency: none (wires only); backpressure: decode stalls the head via id_ready_i.
interface inst_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              ce_o;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_i;
    logic              if_valid_o;
    logic [INST_W-1:0] if_inst_o;
    logic [ADDR_W-1:0] if_pc_o;
    logic              id_ready_i;

    modport master (
        output ce_o, pc_o, if_valid_o, if_inst_o, if_pc_o,
        input  inst_i, id_ready_i
    );

    modport slave (
        input  ce_o, pc_o, if_valid_o, if_inst_o, if_pc_o,
        output inst_i, id_ready_i
    );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// PC sequencer feeding a 2-entry fetch buffer toward decode.
// Latency: instruction valid one edge after ce_o; backpressure: fetch stops when buffer full and not popping.
module inst_fetch_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter int                INST_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                MEM_WORDS = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    inst_fetch_ctrl_if.master bus,
    output logic              misalign_o,
    output logic              end_o
);

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_END,
        S_HALT
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } ent_t;

    localparam logic [ADDR_W-3:0] ROM_LIMIT = (ADDR_W-2)'(MEM_WORDS);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    ent_t              head_q, head_d;
    ent_t              tail_q, tail_d;
    logic [1:0]        cnt_q, cnt_d;

    logic              push;
    logic              pop;
    logic              redirect;
    logic [ADDR_W-1:0] pc_inc;
    ent_t              fetched;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        pop      = (cnt_q != 2'd0) && bus.id_ready_i;
        redirect = branch_flag_i && (state_q == S_RUN || state_q == S_END);
        push     = (state_q == S_RUN) && !stall_i && !branch_flag_i &&
                   ((cnt_q != 2'd2) || pop);
        pc_inc   = pc_q + ADDR_W'(4);
        fetched  = {pc_q, bus.inst_i};

        state_d = state_q;
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_HALT: state_d = S_HALT;
            default: begin
                if (redirect) begin
                    // Flush drops everything, including a head decode took this cycle.
                    cnt_d  = 2'd0;
                    head_d = '0;
                    tail_d = '0;
                    pc_d   = branch_target_i;
                    if (branch_target_i[1:0] != 2'b00)
                        state_d = S_HALT;
                    else if (branch_target_i[ADDR_W-1:2] >= ROM_LIMIT)
                        state_d = S_END;
                    else
                        state_d = S_RUN;
                end else begin
                    if (push && pop) begin
                        if (cnt_q == 2'd1) begin
                            head_d = fetched;
                        end else begin
                            head_d = tail_q;
                            tail_d = fetched;
                        end
                    end else if (pop) begin
                        // Empty slots are kept zero so the head outputs read zero when empty.
                        head_d = tail_q;
                        tail_d = '0;
                        cnt_d  = cnt_q - 2'd1;
                    end else if (push) begin
                        if (cnt_q == 2'd0)
                            head_d = fetched;
                        else
                            tail_d = fetched;
                        cnt_d = cnt_q + 2'd1;
                    end

                    if (push) begin
                        pc_d = pc_inc;
                        if (pc_inc[ADDR_W-1:2] >= ROM_LIMIT)
                            state_d = S_END;
                    end
                end
            end
        endcase
    end

    assign bus.ce_o       = push;
    assign bus.pc_o       = pc_q;
    assign bus.if_valid_o = (cnt_q != 2'd0);
    assign bus.if_inst_o  = head_q.inst;
    assign bus.if_pc_o    = head_q.pc;
    assign misalign_o     = (state_q == S_HALT);
    assign end_o          = (state_q == S_END);

endmodule
